irq_sched: RTL and testbench
============================

Name: irq_sched

Overview:
- Interrupt scheduler for the chad CPU.
- Captures rising edges on up to 2^WIDTH-1 request lines into a pending register and qualifies them with a mask and global enable.
- Picks the highest-numbered qualified request through a prio_enc instance and presents it to the CPU as a vector with a req/ack handshake.
- Blocks further requests until the CPU signals ISR completion, so ISRs never nest.

Parameters:
- WIDTH, 4: vector width; irq has 2^WIDTH lines; bit 0 is unusable because vector 0 means "none".

Ports:
- clk  in  1  system clock
- arst  in  1  reset, asynchronous, active-high
- irq  in  2^WIDTH  request lines, already synchronous to clk; bit 0 ignored
- gie  in  1  global interrupt enable
- mask_we  in  1  write strobe for the mask register
- mask_wdata  in  2^WIDTH  new mask value; 1 = enabled; bit 0 forced 0
- mask  out  2^WIDTH  current mask register
- pending  out  2^WIDTH  current pending register
- irq_req  out  1  interrupt request to CPU
- irq_vec  out  WIDTH  vector number of the request being presented or serviced
- irq_ack  in  1  CPU accepts the request, 1-cycle pulse
- isr_done  in  1  CPU finished the ISR (return-from-interrupt), 1-cycle pulse
- busy  out  1  ISR in service

Behaviour:
- Reset (arst=1, asynchronous) sets:
  - irq_prev=0, pending=0, mask=0
  - state=IDLE, irq_req=0, irq_vec=0, busy=0
- Edge capture: edge[i] = irq[i] & ~irq_prev[i]; irq_prev <= irq every cycle.
- Pending update each cycle: pending <= (pending & ~clr) | edge, with bit 0 forced 0.
  - clr is one-hot(irq_vec) on an accepted ack, else 0.
  - A new edge on the bit being cleared in the same cycle wins: the bit stays set.
- mask_we: mask <= mask_wdata with bit 0 forced 0, effective next cycle.
- Qualification:
  - qual = pending & mask when gie=1, else 0.
  - qual feeds a combinational prio_enc producing sel (highest set bit, 0 if none).
- IDLE:
  - busy=0, irq_req=0.
  - If sel != 0: irq_vec <= sel, irq_req <= 1, go to REQ.
- REQ:
  - irq_req=1; irq_vec is frozen for the whole state.
  - The request is never retracted, even if gie drops, the mask changes or a higher source arrives.
  - On irq_ack: clear pending[irq_vec], irq_req <= 0, busy <= 1, go to SVC.
- SVC:
  - busy=1, irq_req=0, irq_vec holds the serviced vector.
  - Edges keep accumulating in pending.
  - On isr_done: busy <= 0, go to IDLE.
  - A new request can then assert on the cycle after returning to IDLE, evaluated from the updated pending.
- Stray pulses: irq_ack outside REQ and isr_done outside SVC are ignored.
- irq_ack and isr_done high together in REQ: the ack is taken, isr_done is ignored.
- Latency:
  - irq edge sampled at clock edge N sets pending at N.
  - irq_req rises at edge N+1 when IDLE, gie=1 and the source is masked on.
- Mask cleared while pending: the bit stays pending and fires when unmasked, provided gie=1.
- Level-held irq: only one edge per low-to-high transition.
- Reset mid-handshake: all state dropped, nothing pending.

Decomposition:
- Shared package constants:
  - state encoding ST_IDLE=0, ST_REQ=1, ST_SVC=2 (2-bit)
  - VEC_NONE=0
- Sub-module: prio_enc #(.WIDTH(WIDTH)) for sel.
- Remaining RTL is flops plus the FSM: about 150 lines.

Test Plan:
- Reset then mask=16'h0004, gie=1, pulse irq[2] → irq_req=1, irq_vec=2 one cycle after the edge; ack → pending[2]=0, busy=1; isr_done → busy=0, irq_req stays 0.
- Edges on irq[3] and irq[9] in the same cycle, mask=16'hFFFE → vec 9 served first; after isr_done, vec 3 requested next cycle.
- irq[5] edge with mask[5]=0 → pending[5]=1 and no request; write mask[5]=1 → irq_req with vec 5 one cycle later; with gie=0 → no request until gie=1.
- In REQ with vec 4, raise irq[12] and clear gie → irq_req and irq_vec=4 unchanged until ack; after isr_done with gie=1 → vec 12.
- New irq[4] edge in the ack cycle for vec 4 → pending[4] stays 1; re-requested after isr_done.
- Assert arst during SVC with pending=16'h00F0 → pending=0, busy=0, irq_req=0, irq_vec=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/irq_sched_pkg.sv
// Shared types and constants for the interrupt scheduler.
// Imported by the scheduler top, its interface users and the bench.
package irq_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_SVC  = 2'd2
  } state_t;

  localparam int VEC_NONE = 0;

endpackage

// File: rtl/irq_sched_if.sv
// Bundle of the scheduler's request-line, mask and CPU handshake signals.
// Handshake: irq_req/irq_vec stay stable until a 1-cycle irq_ack pulse is seen;
// busy then holds until a 1-cycle isr_done pulse.
interface irq_sched_if #(parameter int WIDTH = 4);
  localparam int N = 2 ** WIDTH;

  logic [N-1:0]     irq;
  logic             gie;
  logic             mask_we;
  logic [N-1:0]     mask_wdata;
  logic [N-1:0]     mask;
  logic [N-1:0]     pending;
  logic             irq_req;
  logic [WIDTH-1:0] irq_vec;
  logic             irq_ack;
  logic             isr_done;
  logic             busy;

  modport slave (
    input  irq, gie, mask_we, mask_wdata, irq_ack, isr_done,
    output mask, pending, irq_req, irq_vec, busy
  );

  modport master (
    output irq, gie, mask_we, mask_wdata, irq_ack, isr_done,
    input  mask, pending, irq_req, irq_vec, busy
  );
endinterface

// File: rtl/irq_sched_prio_enc.sv
// Priority encoder: index of the highest set bit, 0 when none is set.
module prio_enc #(
  parameter int WIDTH = 4
) (
  input  logic [2**WIDTH-1:0] req,
  output logic [WIDTH-1:0]    sel
);

  // Later (higher) indices overwrite earlier ones; bit 0 maps to "none".
  always_comb begin
    sel = '0;
    for (int i = 0; i < 2 ** WIDTH; i++) begin
      if (req[i]) sel = WIDTH'(i);
    end
  end

endmodule

// File: rtl/irq_sched.sv
// Interrupt scheduler: edge capture into pending, mask/gie qualification,
// highest-vector selection and a non-nesting req/ack/done handshake.
module irq_sched
  import irq_sched_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic        clk,
  input  logic        arst,
  irq_sched_if.slave  bus,
  output state_t      dbg_state
);

  localparam int N = 2 ** WIDTH;

  logic [N-1:0]     irq_prev_q, irq_prev_d;
  logic [N-1:0]     pending_q, pending_d;
  logic [N-1:0]     mask_q, mask_d;
  logic [N-1:0]     edge_v, clr, qual;
  logic [WIDTH-1:0] sel;
  logic [WIDTH-1:0] irq_vec_q, irq_vec_d;
  logic             irq_req_q, irq_req_d;
  logic             busy_q, busy_d;
  logic             ack_take;
  state_t           state_q, state_d;

  prio_enc #(.WIDTH(WIDTH)) u_prio_enc (
    .req (qual),
    .sel (sel)
  );

  // Clear and set are applied in that order so a fresh edge on the acked bit survives.
  always_comb begin
    ack_take   = (state_q == ST_REQ) && bus.irq_ack;
    edge_v     = bus.irq & ~irq_prev_q;
    irq_prev_d = bus.irq;
    clr        = '0;
    if (ack_take) clr[irq_vec_q] = 1'b1;
    pending_d    = (pending_q & ~clr) | edge_v;
    pending_d[0] = 1'b0;
    mask_d = mask_q;
    if (bus.mask_we) begin
      mask_d    = bus.mask_wdata;
      mask_d[0] = 1'b0;
    end
    qual = bus.gie ? (pending_q & mask_q) : '0;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (sel != WIDTH'(VEC_NONE)) state_d = ST_REQ;
      ST_REQ:  if (ack_take)                state_d = ST_SVC;
      ST_SVC:  if (bus.isr_done)            state_d = ST_IDLE;
      default:                              state_d = ST_IDLE;
    endcase
  end

  // Request and vector are frozen outside IDLE; only ack/done move them.
  always_comb begin
    irq_req_d = irq_req_q;
    irq_vec_d = irq_vec_q;
    busy_d    = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (sel != WIDTH'(VEC_NONE)) begin
          irq_req_d = 1'b1;
          irq_vec_d = sel;
        end
      end
      ST_REQ: begin
        if (ack_take) begin
          irq_req_d = 1'b0;
          busy_d    = 1'b1;
        end
      end
      ST_SVC: begin
        if (bus.isr_done) busy_d = 1'b0;
      end
      default: begin
        irq_req_d = 1'b0;
        busy_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      irq_prev_q <= '0;
      pending_q  <= '0;
      mask_q     <= '0;
      state_q    <= ST_IDLE;
      irq_req_q  <= 1'b0;
      irq_vec_q  <= WIDTH'(VEC_NONE);
      busy_q     <= 1'b0;
    end else begin
      irq_prev_q <= irq_prev_d;
      pending_q  <= pending_d;
      mask_q     <= mask_d;
      state_q    <= state_d;
      irq_req_q  <= irq_req_d;
      irq_vec_q  <= irq_vec_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.mask    = mask_q;
  assign bus.pending = pending_q;
  assign bus.irq_req = irq_req_q;
  assign bus.irq_vec = irq_vec_q;
  assign bus.busy    = busy_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_irq_sched.sv
// Bench for irq_sched: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a behavioural model.
module tb_irq_sched;
  import irq_sched_pkg::*;

  localparam int WIDTH = 4;
  localparam int N     = 2 ** WIDTH;

  // ---------------- clock / reset ----------------
  logic   clk = 1'b0;
  logic   arst;
  state_t dbg_state;
  always #5 clk = ~clk;

  irq_sched_if #(.WIDTH(WIDTH)) bus();

  irq_sched #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .arst      (arst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [N-1:0]     m_prev, m_pend, m_mask, m_edge;
  int               m_phase;  // 0 idle, 1 presenting, 2 servicing
  int               m_h;
  logic             m_req, m_busy;
  logic [WIDTH-1:0] m_vec;
  logic [WIDTH-1:0] exp_q[$];

  function automatic int highest(input logic [N-1:0] v);
    for (int i = N - 1; i > 0; i--) if (v[i]) return i;
    return 0;
  endfunction

  always @(posedge clk or posedge arst) begin
    if (arst) begin
      m_prev = '0; m_pend = '0; m_mask = '0;
      m_phase = 0; m_req = 1'b0; m_busy = 1'b0; m_vec = '0;
      exp_q.delete();
    end else begin
      m_edge = bus.irq & ~m_prev;
      m_prev = bus.irq;
      m_h    = bus.gie ? highest(m_pend & m_mask) : 0;
      case (m_phase)
        0: if (m_h != 0) begin
             m_req = 1'b1; m_vec = WIDTH'(m_h); m_phase = 1;
             exp_q.push_back(m_vec);
           end
        1: if (bus.irq_ack) begin
             m_pend[m_vec] = 1'b0; m_req = 1'b0; m_busy = 1'b1; m_phase = 2;
           end
        default: if (bus.isr_done) begin
             m_busy = 1'b0; m_phase = 0;
           end
      endcase
      m_pend    = m_pend | m_edge;
      m_pend[0] = 1'b0;
      if (bus.mask_we) begin
        m_mask    = bus.mask_wdata;
        m_mask[0] = 1'b0;
      end
    end
  end

  // ---------------- scoreboard / per-cycle compare ----------------
  logic last_req = 1'b0;
  always @(negedge clk) begin
    if (arst) begin
      last_req = 1'b0;
    end else if (chk_en) begin
      chk("cyc_pending", bus.pending, m_pend);
      chk("cyc_mask",    bus.mask,    m_mask);
      chk("cyc_irq_req", bus.irq_req, m_req);
      chk("cyc_irq_vec", bus.irq_vec, m_vec);
      chk("cyc_busy",    bus.busy,    m_busy);
      if (bus.irq_req && !last_req) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL sb_vec: request vec %0d with no expected entry", bus.irq_vec);
        end else begin
          chk("sb_vec", bus.irq_vec, exp_q.pop_front());
        end
      end
      last_req = bus.irq_req;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic write_mask(input logic [N-1:0] v);
    bus.mask_we = 1'b1; bus.mask_wdata = v;
    step();
    bus.mask_we = 1'b0;
  endtask

  task automatic raise(input logic [N-1:0] bits);
    bus.irq = bus.irq | bits;
    step();
    bus.irq = bus.irq & ~bits;
  endtask

  task automatic pulse_ack();
    bus.irq_ack = 1'b1; step(); bus.irq_ack = 1'b0;
  endtask

  task automatic pulse_done();
    bus.isr_done = 1'b1; step(); bus.isr_done = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    arst = 1'b1;
    bus.irq = '0; bus.gie = 1'b0; bus.mask_we = 1'b0; bus.mask_wdata = '0;
    bus.irq_ack = 1'b0; bus.isr_done = 1'b0;
    step(2);
    arst = 1'b0;
    step();
    chk_en = 1'b1;
    chk("rst_pending", bus.pending, 16'h0000);
    chk("rst_mask",    bus.mask,    16'h0000);
    chk("rst_req",     bus.irq_req, 1'b0);
    chk("rst_vec",     bus.irq_vec, 4'd0);
    chk("rst_busy",    bus.busy,    1'b0);

    // Single source, full handshake
    bus.gie = 1'b1;
    write_mask(16'h0004);
    raise(16'h0004);
    chk("t1_pend", bus.pending, 16'h0004);
    chk("t1_req0", bus.irq_req, 1'b0);
    step();
    chk("t1_req",  bus.irq_req, 1'b1);
    chk("t1_vec",  bus.irq_vec, 4'd2);
    pulse_ack();
    chk("t1_pend_clr", bus.pending, 16'h0000);
    chk("t1_busy", bus.busy, 1'b1);
    pulse_done();
    chk("t1_busy0", bus.busy, 1'b0);
    step();
    chk("t1_noreq", bus.irq_req, 1'b0);

    // Two simultaneous edges: highest first, then the other
    write_mask(16'hFFFE);
    raise(16'h0208);
    step();
    chk("t2_vec9", bus.irq_vec, 4'd9);
    pulse_ack();
    pulse_done();
    chk("t2_idle", bus.irq_req, 1'b0);
    step();
    chk("t2_req3", bus.irq_req, 1'b1);
    chk("t2_vec3", bus.irq_vec, 4'd3);
    pulse_ack(); pulse_done();

    // Masked source stays pending; fires on unmask; gie gating
    write_mask(16'hFFDE);
    raise(16'h0020);
    step();
    chk("t3_pend5", bus.pending[5], 1'b1);
    chk("t3_noreq", bus.irq_req, 1'b0);
    write_mask(16'hFFFE);
    chk("t3_noreq_wr", bus.irq_req, 1'b0);
    step();
    chk("t3_req5", bus.irq_vec, 4'd5);
    pulse_ack(); pulse_done();
    bus.gie = 1'b0;
    raise(16'h0020);
    step(2);
    chk("t3_gie_off", bus.irq_req, 1'b0);
    bus.gie = 1'b1;
    step();
    chk("t3_gie_on", bus.irq_req, 1'b1);
    pulse_ack(); pulse_done();

    // Request never retracted
    raise(16'h0010);
    step();
    chk("t4_vec4", bus.irq_vec, 4'd4);
    bus.gie = 1'b0;
    raise(16'h1000);
    step(2);
    chk("t4_hold_req", bus.irq_req, 1'b1);
    chk("t4_hold_vec", bus.irq_vec, 4'd4);
    pulse_ack();
    bus.gie = 1'b1;
    pulse_done();
    step();
    chk("t4_vec12", bus.irq_vec, 4'd12);
    pulse_ack(); pulse_done();

    // New edge in the ack cycle wins over the clear
    raise(16'h0010);
    step();
    chk("t5_vec4", bus.irq_vec, 4'd4);
    bus.irq[4] = 1'b1; bus.irq_ack = 1'b1;
    step();
    bus.irq[4] = 1'b0; bus.irq_ack = 1'b0;
    chk("t5_pend4", bus.pending[4], 1'b1);
    chk("t5_busy",  bus.busy, 1'b1);
    pulse_done();
    step();
    chk("t5_rereq", bus.irq_req, 1'b1);
    chk("t5_revec", bus.irq_vec, 4'd4);
    pulse_ack(); pulse_done();

    // Asynchronous reset in service
    raise(16'h0010);
    step();
    pulse_ack();
    bus.irq = 16'h00F0;
    step();
    bus.irq = '0;
    chk("t6_pend", bus.pending, 16'h00F0);
    chk("t6_busy", bus.busy, 1'b1);
    #1 arst = 1'b1;
    #1;
    chk("t6_rst_pend", bus.pending, 16'h0000);
    chk("t6_rst_busy", bus.busy, 1'b0);
    chk("t6_rst_req",  bus.irq_req, 1'b0);
    chk("t6_rst_vec",  bus.irq_vec, 4'd0);
    step();
    arst = 1'b0;
    step();

    // Randomized run against the model
    write_mask(16'($urandom()) | 16'h0F00);
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 3) == 0) bus.irq = bus.irq ^ (16'h1 << $urandom_range(0, N - 1));
      bus.gie        = ($urandom_range(0, 9) != 0);
      bus.mask_we    = ($urandom_range(0, 19) == 0);
      bus.mask_wdata = 16'($urandom());
      bus.irq_ack    = ($urandom_range(0, 2) == 0);
      bus.isr_done   = ($urandom_range(0, 3) == 0);
      step();
    end
    bus.irq = '0; bus.mask_we = 1'b0; bus.irq_ack = 1'b0; bus.isr_done = 1'b0;
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
